// File: rtl/power_fault_responder.sv
// Power fault responder: glitch-filters converter power-good bits, sequences converter
// enables up in order and down in reverse, latches faults and pulses an interrupt.
module power_fault_responder #(
  parameter int unsigned NumConverters = 1,
  parameter int unsigned FilterCount   = 3,
  parameter logic [15:0] StepCycles    = 16'd1000,
  parameter logic [15:0] PgoodTimeout  = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fault,
  input  logic        warn,
  input  logic        eoc,
  input  logic [31:0] pgood_bus,
  input  logic        en_req,
  input  logic        ack,
  output logic [31:0] conv_en,
  output logic [31:0] pgood_filt,
  output logic        fault_latched,
  output logic        irq,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StSeqUp   = 3'd1,
    StOn      = 3'd2,
    StSeqDown = 3'd3,
    StFault   = 3'd4
  } state_e;

  localparam logic [31:0] ValidMask = (NumConverters >= 32) ? 32'hFFFF_FFFF :
                                      ((32'd1 << NumConverters) - 32'd1);
  localparam logic [4:0]  LastIdx   = 5'(NumConverters - 1);
  localparam logic [3:0]  FiltLimit = 4'(FilterCount);
  // Decisions are taken on the edge that completes the Nth cycle of a step, so compare
  // against N-1 of the registered count.
  localparam logic [15:0] StepLast    = StepCycles - 16'd1;
  localparam logic [15:0] TimeoutLast = PgoodTimeout - 16'd1;

  logic [3:0]               cnt_q [NumConverters];
  logic [NumConverters-1:0] filt_q;
  logic [31:0]              filt_full;

  state_e      state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [15:0] timer_q, timer_d;
  logic        abort_q, abort_d;
  logic [31:0] conv_en_q, conv_en_d;
  logic        latched_q, latched_d;
  logic        armed_q, armed_d;
  logic        warn_q;
  logic        irq_q, irq_d;

  logic unused_pgood;
  assign unused_pgood = ^(pgood_bus & ~ValidMask);

  // Per-bit filter: count consecutive eoc samples that disagree with the filtered value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumConverters; i++) cnt_q[i] <= '0;
      filt_q <= '0;
    end else if (eoc) begin
      for (int i = 0; i < NumConverters; i++) begin
        if (pgood_bus[i] != filt_q[i]) begin
          if (cnt_q[i] + 4'd1 == FiltLimit) begin
            filt_q[i] <= ~filt_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Widen the filtered bits to the 32-bit bus so k can index them directly.
  always_comb begin
    filt_full = '0;
    filt_full[NumConverters-1:0] = filt_q;
  end

  // Sequencer next-state, enables, fault latch, re-arm and interrupt sources.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    timer_d   = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    abort_d   = abort_q;
    conv_en_d = conv_en_q;
    latched_d = latched_q;
    // A low en_req re-arms power-up after a fault has been acknowledged.
    armed_d   = armed_q | ~en_req;
    unique case (state_q)
      StOff: begin
        if (en_req && !fault && armed_q) begin
          state_d      = StSeqUp;
          k_d          = 5'd0;
          timer_d      = '0;
          conv_en_d[0] = 1'b1;
        end
      end
      StSeqUp: begin
        if (fault || !en_req) begin
          state_d        = StSeqDown;
          abort_d        = fault;
          conv_en_d[k_q] = 1'b0;
          timer_d        = '0;
        end else if (filt_full[k_q] && timer_q >= StepLast) begin
          timer_d = '0;
          if (k_q == LastIdx) begin
            state_d = StOn;
          end else begin
            k_d                   = k_q + 5'd1;
            conv_en_d[k_q + 5'd1] = 1'b1;
          end
        end else if (!filt_full[k_q] && timer_q >= TimeoutLast) begin
          state_d        = StSeqDown;
          abort_d        = 1'b1;
          conv_en_d[k_q] = 1'b0;
          timer_d        = '0;
        end
      end
      StOn: begin
        if (fault || !(&filt_q) || !en_req) begin
          state_d            = StSeqDown;
          abort_d            = fault || !(&filt_q);
          k_d                = LastIdx;
          conv_en_d[LastIdx] = 1'b0;
          timer_d            = '0;
        end
      end
      StSeqDown: begin
        if (timer_q >= StepLast) begin
          timer_d = '0;
          if (k_q == 5'd0) begin
            state_d = abort_q ? StFault : StOff;
            if (abort_q) latched_d = 1'b1;
          end else begin
            k_d                   = k_q - 5'd1;
            conv_en_d[k_q - 5'd1] = 1'b0;
          end
        end
      end
      StFault: begin
        conv_en_d = '0;
        if (ack && !fault) begin
          state_d   = StOff;
          latched_d = 1'b0;
          armed_d   = ~en_req;
        end
      end
      default: begin
        state_d   = StOff;
        conv_en_d = '0;
      end
    endcase
    irq_d = ((state_d == StOn) && (state_q != StOn)) ||
            ((state_d == StFault) && (state_q != StFault)) ||
            (warn && !warn_q);
  end

  // Sequencer state registers; reset drops every output immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StOff;
      k_q       <= '0;
      timer_q   <= '0;
      abort_q   <= 1'b0;
      conv_en_q <= '0;
      latched_q <= 1'b0;
      armed_q   <= 1'b1;
      warn_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      timer_q   <= timer_d;
      abort_q   <= abort_d;
      conv_en_q <= conv_en_d;
      latched_q <= latched_d;
      armed_q   <= armed_d;
      warn_q    <= warn;
      irq_q     <= irq_d;
    end
  end

  assign conv_en       = conv_en_q & ValidMask;
  assign pgood_filt    = filt_full;
  assign fault_latched = latched_q;
  assign irq           = irq_q;
  assign state         = state_q;

endmodule

// File: tb/tb_power_fault_responder.sv
// Self-checking bench for power_fault_responder (4 converters, filter 2, step 4, timeout 20).
module tb_power_fault_responder;

  logic        clock, reset, fault, warn, eoc, en_req, ack;
  logic [31:0] pgood_bus, conv_en, pgood_filt;
  logic        fault_latched, irq;
  logic [2:0]  state;

  int          checks = 0;
  int          errors = 0;
  logic        auto_pg;
  logic [31:0] pg_mask;
  logic [31:0] sb_q[$];
  int          chg_cyc[$];
  int          irq_cnt;

  typedef struct {
    logic        eoc;
    logic [31:0] bus;
    logic [31:0] exp_filt;
  } fvec_t;
  fvec_t fv[15];

  power_fault_responder #(
    .NumConverters(4),
    .FilterCount(2),
    .StepCycles(16'd4),
    .PgoodTimeout(16'd20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fault(fault),
    .warn(warn),
    .eoc(eoc),
    .pgood_bus(pgood_bus),
    .en_req(en_req),
    .ack(ack),
    .conv_en(conv_en),
    .pgood_filt(pgood_filt),
    .fault_latched(fault_latched),
    .irq(irq),
    .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the edge. In auto mode the converters
  // report power-good for their own enable, with eoc every other cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (auto_pg) begin
      eoc       = ~eoc;
      pgood_bus = conv_en & pg_mask;
    end
  endtask

  // Compare each conv_en change against the queued expectations until target state.
  task automatic watch(input string name, input logic [2:0] target, input int budget);
    logic [31:0] prev;
    prev = conv_en;
    chg_cyc.delete();
    irq_cnt = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (irq) irq_cnt++;
      if (conv_en != prev) begin
        chg_cyc.push_back(c);
        if (sb_q.size() == 0) check({name, " extra step"}, conv_en, prev);
        else check({name, " step"}, conv_en, sb_q.pop_front());
        prev = conv_en;
      end
      if (state == target && sb_q.size() == 0) break;
    end
    check({name, " end state"}, 32'(state), 32'(target));
    check({name, " pending steps"}, sb_q.size(), 0);
    sb_q.delete();
    repeat (3) begin
      tick();
      if (irq) irq_cnt++;
    end
  endtask

  initial begin
    reset = 1'b0; fault = 1'b0; warn = 1'b0; eoc = 1'b0; en_req = 1'b0; ack = 1'b0;
    pgood_bus = '0; auto_pg = 1'b0; pg_mask = '0;

    fv[0]  = '{1'b1, 32'h1,  32'h0};  // first disagreeing sample
    fv[1]  = '{1'b0, 32'h1,  32'h0};  // no eoc: nothing moves
    fv[2]  = '{1'b1, 32'h0,  32'h0};  // single-sample glitch rejected
    fv[3]  = '{1'b1, 32'h1,  32'h0};
    fv[4]  = '{1'b1, 32'h1,  32'h1};  // second consecutive sample toggles
    fv[5]  = '{1'b0, 32'h0,  32'h1};
    fv[6]  = '{1'b1, 32'h0,  32'h1};
    fv[7]  = '{1'b1, 32'h0,  32'h0};
    fv[8]  = '{1'b1, 32'h3F, 32'h0};
    fv[9]  = '{1'b1, 32'h3F, 32'hF};  // bits above NumConverters stay 0
    fv[10] = '{1'b1, 32'h5,  32'hF};
    fv[11] = '{1'b1, 32'h5,  32'h5};
    fv[12] = '{1'b1, 32'h4,  32'h5};
    fv[13] = '{1'b0, 32'h4,  32'h5};  // count held across a gap between eoc pulses
    fv[14] = '{1'b1, 32'h4,  32'h4};

    // Asynchronous reset, observed before the first clock edge.
    #2 reset = 1'b1;
    #1;
    check("reset conv_en", conv_en, 32'h0);
    check("reset pgood_filt", pgood_filt, 32'h0);
    check("reset fault_latched", 32'(fault_latched), 0);
    check("reset irq", 32'(irq), 0);
    check("reset state", 32'(state), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();

    // Rising warn gives exactly one irq pulse.
    warn = 1'b1;
    tick();
    check("warn irq pulse", 32'(irq), 1);
    tick();
    check("warn irq held", 32'(irq), 0);
    warn = 1'b0;
    tick();
    check("warn irq fall", 32'(irq), 0);

    // Filter vectors.
    for (int i = 0; i < 15; i++) begin
      eoc       = fv[i].eoc;
      pgood_bus = fv[i].bus;
      sb_q.push_back(fv[i].exp_filt);
      tick();
      check($sformatf("filter vec %0d", i), pgood_filt, sb_q.pop_front());
    end
    pgood_bus = '0;
    eoc       = 1'b1;
    repeat (2) tick();
    eoc = 1'b0;
    tick();
    check("filter cleared", pgood_filt, 32'h0);
    check("filter state off", 32'(state), 0);

    // Power-up in order.
    auto_pg = 1'b1;
    pg_mask = 32'hF;
    sb_q.push_back(32'h1); sb_q.push_back(32'h3); sb_q.push_back(32'h7); sb_q.push_back(32'hF);
    en_req = 1'b1;
    watch("power-up", 3'd2, 200);
    for (int i = 1; i < chg_cyc.size(); i++)
      check($sformatf("power-up gap %0d >= 4", i), 32'(chg_cyc[i] - chg_cyc[i-1] >= 4), 1);
    check("power-up irq count", irq_cnt, 1);

    // Fault while on: reverse shutdown, then FAULT.
    sb_q.push_back(32'h7); sb_q.push_back(32'h3); sb_q.push_back(32'h1); sb_q.push_back(32'h0);
    fault = 1'b1;
    watch("fault-in-on", 3'd4, 200);
    for (int i = 1; i < chg_cyc.size(); i++)
      check($sformatf("fault-in-on gap %0d", i), chg_cyc[i] - chg_cyc[i-1], 4);
    check("fault-in-on latched", 32'(fault_latched), 1);
    check("fault-in-on irq count", irq_cnt, 1);

    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("ack during fault state", 32'(state), 4);
    check("ack during fault latched", 32'(fault_latched), 1);
    fault = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack clears state", 32'(state), 0);
    check("ack clears latched", 32'(fault_latched), 0);

    // en_req still high: no restart until it has been seen low.
    repeat (10) tick();
    check("no restart state", 32'(state), 0);
    check("no restart conv_en", conv_en, 32'h0);
    en_req = 1'b0;
    tick();
    en_req = 1'b1;
    tick();
    check("re-armed start", 32'(state), 1);

    // Asynchronous reset in the middle of power-up.
    for (int c = 0; c < 50 && conv_en != 32'h3; c++) tick();
    check("reached conv_en 3", conv_en, 32'h3);
    #2 reset = 1'b1;
    #1;
    check("mid-seq reset conv_en", conv_en, 32'h0);
    check("mid-seq reset state", 32'(state), 0);
    #2 reset = 1'b0;

    // Power up again, then a normal power-down.
    sb_q.push_back(32'h1); sb_q.push_back(32'h3); sb_q.push_back(32'h7); sb_q.push_back(32'hF);
    watch("power-up 2", 3'd2, 200);
    check("power-up 2 irq count", irq_cnt, 1);
    sb_q.push_back(32'h7); sb_q.push_back(32'h3); sb_q.push_back(32'h1); sb_q.push_back(32'h0);
    en_req = 1'b0;
    watch("normal off", 3'd0, 200);
    check("normal off latched", 32'(fault_latched), 0);
    check("normal off irq count", irq_cnt, 0);

    // Power-good timeout on converter 1.
    pg_mask = 32'h1;
    sb_q.push_back(32'h1); sb_q.push_back(32'h3); sb_q.push_back(32'h1); sb_q.push_back(32'h0);
    en_req = 1'b1;
    watch("timeout", 3'd4, 300);
    if (chg_cyc.size() >= 4) begin
      check("timeout delay", chg_cyc[2] - chg_cyc[1], 20);
      check("timeout down gap", chg_cyc[3] - chg_cyc[2], 4);
    end
    check("timeout latched", 32'(fault_latched), 1);
    check("timeout irq count", irq_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
